// File: rtl/mini_alu.sv
// mini_alu: single-cycle 6-bit ALU with registered result, flags and valid strobe.
module mini_alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] A,
    input  logic [5:0] B,
    input  logic [2:0] fxn,
    output logic [5:0] X,
    output logic       out_valid,
    output logic       zero,
    output logic       carry,
    output logic       overflow
);

    localparam int unsigned DW = 6;
    localparam int unsigned SW = 3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    // Result and flags travel together so they always update as one unit.
    typedef struct packed {
        logic [DW-1:0] x;
        logic          zero;
        logic          carry;
        logic          overflow;
    } result_t;

    localparam result_t RESULT_RST = '{x: '0, zero: 1'b1, carry: 1'b0, overflow: 1'b0};

    result_t        res_d;
    result_t        res_q;
    logic           out_valid_d;
    logic           out_valid_q;

    logic [DW:0]    sum_ext;
    logic [DW:0]    diff_ext;
    logic [SW-1:0]  shamt;
    logic           borrow;
    logic           add_ovf;
    logic           sub_ovf;

    // Shared arithmetic: 7-bit sum/difference give carry and borrow directly.
    always_comb begin
        sum_ext  = {1'b0, A} + {1'b0, B};
        diff_ext = {1'b0, A} - {1'b0, B};
        borrow   = diff_ext[DW];
        shamt    = B[SW-1:0];
        add_ovf  = (A[DW-1] == B[DW-1]) && (sum_ext[DW-1]  != A[DW-1]);
        sub_ovf  = (A[DW-1] != B[DW-1]) && (diff_ext[DW-1] != A[DW-1]);
    end

    // Next result: operation select, flags, and hold when no new input.
    always_comb begin
        res_d       = res_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_valid_d    = 1'b1;
            res_d.carry    = 1'b0;
            res_d.overflow = 1'b0;
            unique case (fxn)
                OP_ADD: begin
                    res_d.x        = sum_ext[DW-1:0];
                    res_d.carry    = sum_ext[DW];
                    res_d.overflow = add_ovf;
                end
                OP_SUB: begin
                    res_d.x        = diff_ext[DW-1:0];
                    res_d.carry    = borrow;
                    res_d.overflow = sub_ovf;
                end
                OP_AND:  res_d.x = A & B;
                OP_OR:   res_d.x = A | B;
                OP_XOR:  res_d.x = A ^ B;
                // Shifting a 6-bit value by 6 or 7 naturally yields zero.
                OP_SLL:  res_d.x = DW'(A << shamt);
                OP_SRL:  res_d.x = DW'(A >> shamt);
                OP_SLTU: res_d.x = DW'(borrow);
                default: res_d.x = '0;
            endcase
            res_d.zero = (res_d.x == '0);
        end
    end

    // Output registers with asynchronous reset; reset also discards any sampled transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= RESULT_RST;
            out_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign X         = res_q.x;
    assign zero      = res_q.zero;
    assign carry     = res_q.carry;
    assign overflow  = res_q.overflow;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mini_alu.sv
// Directed self-checking bench for mini_alu.
module tb_mini_alu;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] A;
    logic [5:0] B;
    logic [2:0] fxn;
    logic [5:0] X;
    logic       out_valid;
    logic       zero;
    logic       carry;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [2:0] f;
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] x;
        logic       c;
        logic       o;
        logic       z;
    } vec_t;

    mini_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .fxn       (fxn),
        .X         (X),
        .out_valid (out_valid),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation on the falling edge; return just after the sampling edge.
    task automatic issue(input logic [2:0] f, input logic [5:0] a, input logic [5:0] b);
        @(negedge clk);
        fxn      = f;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        fxn      = 3'b000;
        A        = 6'd25;
        B        = 6'd42;
        repeat (2) @(posedge clk);
        #1;
        if (X !== 6'd0) begin errors++; $display("FAIL reset_X: got %b expected %b", X, 6'd0); end
        checks++;
        if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", zero); end
        checks++;
        if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        if (out_valid !== 1'b0 || X !== 6'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got out_valid=%b X=%b expected out_valid=0 X=000000", out_valid, X);
        end
        checks++;
    endtask

    // Every operation issued back-to-back: one result per cycle, out_valid never drops.
    task automatic test_back_to_back();
        vec_t v[$];
        v.push_back('{"add_carry",   3'b000, 6'b011001, 6'b101010, 6'b000011, 1'b1, 1'b0, 1'b0});
        v.push_back('{"sub_plain",   3'b001, 6'b111100, 6'b001111, 6'b101101, 1'b0, 1'b0, 1'b0});
        v.push_back('{"sub_borrow",  3'b001, 6'b000000, 6'b000001, 6'b111111, 1'b1, 1'b0, 1'b0});
        v.push_back('{"sub_ovf",     3'b001, 6'b100000, 6'b000001, 6'b011111, 1'b0, 1'b1, 1'b0});
        v.push_back('{"add_wrap0",   3'b000, 6'b100000, 6'b100000, 6'b000000, 1'b1, 1'b1, 1'b1});
        v.push_back('{"xor",         3'b100, 6'b000101, 6'b001100, 6'b001001, 1'b0, 1'b0, 1'b0});
        v.push_back('{"srl_2",       3'b110, 6'b010101, 6'b001010, 6'b000101, 1'b0, 1'b0, 1'b0});
        v.push_back('{"srl_3",       3'b110, 6'b010010, 6'b000011, 6'b000010, 1'b0, 1'b0, 1'b0});
        v.push_back('{"sll_5",       3'b101, 6'b111100, 6'b110101, 6'b000000, 1'b0, 1'b0, 1'b1});
        v.push_back('{"sll_6",       3'b101, 6'b000001, 6'b000110, 6'b000000, 1'b0, 1'b0, 1'b1});
        v.push_back('{"srl_7",       3'b110, 6'b111111, 6'b000111, 6'b000000, 1'b0, 1'b0, 1'b1});
        v.push_back('{"sll_hi_ign",  3'b101, 6'b000011, 6'b111001, 6'b000110, 1'b0, 1'b0, 1'b0});
        v.push_back('{"srl_5",       3'b110, 6'b100000, 6'b000101, 6'b000001, 1'b0, 1'b0, 1'b0});
        v.push_back('{"add_ovf",     3'b000, 6'b011111, 6'b000001, 6'b100000, 1'b0, 1'b1, 1'b0});
        v.push_back('{"sltu_lt",     3'b111, 6'b000011, 6'b000100, 6'b000001, 1'b0, 1'b0, 1'b0});
        v.push_back('{"sltu_eq",     3'b111, 6'b000100, 6'b000100, 6'b000000, 1'b0, 1'b0, 1'b1});
        v.push_back('{"sltu_gt",     3'b111, 6'b111111, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1});
        v.push_back('{"and",         3'b010, 6'b110110, 6'b011011, 6'b010010, 1'b0, 1'b0, 1'b0});
        v.push_back('{"or",          3'b011, 6'b100100, 6'b000011, 6'b100111, 1'b0, 1'b0, 1'b0});
        foreach (v[i]) begin
            issue(v[i].f, v[i].a, v[i].b);
            if (X !== v[i].x) begin errors++; $display("FAIL %s X: got %b expected %b", v[i].name, X, v[i].x); end
            checks++;
            if (carry !== v[i].c) begin errors++; $display("FAIL %s carry: got %b expected %b", v[i].name, carry, v[i].c); end
            checks++;
            if (overflow !== v[i].o) begin errors++; $display("FAIL %s overflow: got %b expected %b", v[i].name, overflow, v[i].o); end
            checks++;
            if (zero !== v[i].z) begin errors++; $display("FAIL %s zero: got %b expected %b", v[i].name, zero, v[i].z); end
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid: got %b expected 1", v[i].name, out_valid); end
            checks++;
        end
    endtask

    // Idle cycles after a result must hold X and flags with out_valid low.
    task automatic test_hold();
        issue(3'b000, 6'b011111, 6'b000001);
        if (X !== 6'b100000 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL hold_setup: got X=%b ovf=%b expected X=100000 ovf=1", X, overflow);
        end
        checks++;
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_out_valid[%0d]: got %b expected 0", k, out_valid); end
            checks++;
            if (X !== 6'b100000) begin errors++; $display("FAIL hold_X[%0d]: got %b expected 100000", k, X); end
            checks++;
            if (overflow !== 1'b1 || carry !== 1'b0 || zero !== 1'b0) begin
                errors++;
                $display("FAIL hold_flags[%0d]: got o=%b c=%b z=%b expected o=1 c=0 z=0", k, overflow, carry, zero);
            end
            checks++;
        end
    endtask

    // Mid-cycle reset clears outputs immediately and ignores in_valid while held.
    task automatic test_async_reset();
        issue(3'b000, 6'b011001, 6'b101010);
        if (X !== 6'b000011 || carry !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: got X=%b c=%b expected X=000011 c=1", X, carry);
        end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (X !== 6'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL areset_immediate: got X=%b z=%b expected X=000000 z=1", X, zero);
        end
        checks++;
        if (carry !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_flags: got c=%b o=%b v=%b expected 0 0 0", carry, overflow, out_valid);
        end
        checks++;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            if (X !== 6'd0 || out_valid !== 1'b0 || zero !== 1'b1) begin
                errors++;
                $display("FAIL areset_held[%0d]: got X=%b v=%b z=%b expected X=000000 v=0 z=1", k, X, out_valid, zero);
            end
            checks++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        issue(3'b100, 6'b000101, 6'b001100);
        if (X !== 6'b001001 || out_valid !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL first_after_reset: got X=%b v=%b z=%b expected X=001001 v=1 z=0", X, out_valid, zero);
        end
        checks++;
        idle_cycle();
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b expected 0", out_valid); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
